// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential ROM reads, absorbs the ROM's
// one-cycle read latency and buffers the fetched words, each tagged with its
// address, in a small FIFO ahead of the instruction processor. A redirect
// flushes everything buffered or in flight and restarts fetching.
//
// Handshake: the consumer side is valid/ready. instr_valid/instr_data/instr_pc
// come from registered FIFO state and do not depend on instr_ready; a word
// transfers on a rising edge where instr_valid & instr_ready are both high
// (and no redirect is active). The ROM side has no handshake: each address is
// sampled on every edge and its data returns exactly one cycle later.
module instruction_fetch_queue #(
  parameter int unsigned       WIDTH      = 16,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] rom_addr,
  output logic             rom_rd,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_addr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  // Fetch state
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] pend_tag_q, pend_tag_d;

  // FIFO state
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Internal control
  logic [CW-1:0]    credit_used;
  logic             credit_ok;
  logic             push;
  logic             pop;

  // Issue decision, ROM address mux and registered-head output view
  always_comb begin
    credit_used = count_q + CW'(pending_q);
    credit_ok   = (credit_used < CW'(DEPTH));

    instr_valid = reset_n & (count_q != '0);
    instr_data  = instr_valid ? data_q[rd_ptr_q] : '0;
    instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : '0;

    rom_addr = fetch_pc_q;
    rom_rd   = credit_ok;
    if (!reset_n) begin
      rom_addr = RESET_ADDR;
      rom_rd   = 1'b0;
    end else if (redirect) begin
      // Bypass so the new target is read this very cycle
      rom_addr = redirect_addr;
      rom_rd   = 1'b1;
    end

    // Data returning during a redirect belongs to the old stream: drop it
    push = reset_n & ~redirect & pending_q;
    pop  = instr_valid & instr_ready & ~redirect;
  end

  // Next-state logic for fetch pointer, in-flight tag and FIFO bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pending_d  = 1'b0;
    pend_tag_d = pend_tag_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_addr + WIDTH'(1);
      pending_d  = 1'b1;
      pend_tag_d = redirect_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (credit_ok) begin
        fetch_pc_d = fetch_pc_q + WIDTH'(1);
        pending_d  = 1'b1;
        pend_tag_d = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_ADDR;
      pending_q  <= 1'b0;
      pend_tag_q <= RESET_ADDR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      pend_tag_q <= pend_tag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: capture the returning word with the address it was fetched from
  always_ff @(posedge clock) begin
    if (push) begin
      data_q[wr_ptr_q] <= rom_data;
      pc_q[wr_ptr_q]   <= pend_tag_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Testbench for instruction_fetch_queue: a behavioural ROM, directed stimulus
// that queues the expected {pc, data} stream, and a monitor that pops and
// compares every word the consumer accepts.
module tb_instruction_fetch_queue;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         redirect = 1'b0;
  logic [W-1:0] redirect_addr = '0;
  logic         instr_ready = 1'b0;

  logic [W-1:0] rom_addr;
  logic         rom_rd;
  logic [W-1:0] rom_data;
  logic         instr_valid;
  logic [W-1:0] instr_data;
  logic [W-1:0] instr_pc;

  always #5 clock = ~clock;

  instruction_fetch_queue #(
    .WIDTH(W),
    .DEPTH(4),
    .RESET_ADDR(16'h0000)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rom_addr     (rom_addr),
    .rom_rd       (rom_rd),
    .rom_data     (rom_data),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready)
  );

  // ROM contents: ROM[i] = 16'hA000 + i (mod 2^16), one-cycle read latency
  function automatic logic [W-1:0] rom_word(input logic [W-1:0] a);
    return 16'hA000 + a;
  endfunction

  always @(posedge clock) rom_data <= rom_word(rom_addr);

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          accepted = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_exp(input logic [W-1:0] start, input int n);
    logic [W-1:0] p;
    for (int i = 0; i < n; i++) begin
      p = start + W'(i);
      exp_q.push_back({p, rom_word(p)});
    end
  endtask

  // Monitor: every accepted word must be the next expected one
  always @(negedge clock) begin
    if (reset_n && instr_valid && instr_ready && !redirect) begin
      accepted++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got pc=%h data=%h, expected no word", instr_pc, instr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("scoreboard_word", {instr_pc, instr_data}, mon_exp);
      end
    end
    if (!instr_valid) begin
      chk("idle_data_zero", 32'(instr_data), 32'h0);
      chk("idle_pc_zero", 32'(instr_pc), 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  int          base;
  logic [15:0] wrap_pcs [4];

  initial begin
    wrap_pcs[0] = 16'hFFFE;
    wrap_pcs[1] = 16'hFFFF;
    wrap_pcs[2] = 16'h0000;
    wrap_pcs[3] = 16'h0001;

    // Reset held for several edges
    repeat (3) tick();
    neg();
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rom_rd", 32'(rom_rd), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);

    // S1: streaming with ready high
    tick(); reset_n = 1'b1; instr_ready = 1'b1; load_exp(16'h0000, 40); base = accepted;
    neg();
    chk("s1_c0_rom_rd", 32'(rom_rd), 32'h1);
    chk("s1_c0_rom_addr", 32'(rom_addr), 32'h0);
    chk("s1_c0_valid", 32'(instr_valid), 32'h0);
    tick(); neg();
    chk("s1_c1_valid", 32'(instr_valid), 32'h0);
    tick(); neg();
    chk("s1_c2_valid", 32'(instr_valid), 32'h1);
    chk("s1_c2_pc", 32'(instr_pc), 32'h0);
    chk("s1_c2_data", 32'(instr_data), 32'hA000);
    for (int k = 3; k < 10; k++) begin
      tick(); neg();
      chk("s1_no_bubble", 32'(instr_valid), 32'h1);
    end
    tick(); instr_ready = 1'b0;
    chk("s1_accepted", 32'(accepted - base), 32'd8);

    // Mid-operation reset: everything drops to zero
    reset_n = 1'b0; exp_q.delete();
    neg();
    chk("mid_rst_valid", 32'(instr_valid), 32'h0);
    chk("mid_rst_rom_rd", 32'(rom_rd), 32'h0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'h0);

    // S2: backpressure from release
    tick(); reset_n = 1'b1; load_exp(16'h0000, 40);
    neg();
    chk("s2_c0_rom_rd", 32'(rom_rd), 32'h1);
    tick(); tick(); tick(); neg();
    chk("s2_c3_rom_rd", 32'(rom_rd), 32'h1);
    chk("s2_c3_rom_addr", 32'(rom_addr), 32'h3);
    tick(); neg();
    chk("s2_c4_rom_rd", 32'(rom_rd), 32'h0);
    chk("s2_c4_rom_addr", 32'(rom_addr), 32'h4);
    tick(); neg();
    chk("s2_full_rom_rd", 32'(rom_rd), 32'h0);
    chk("s2_full_rom_addr", 32'(rom_addr), 32'h4);
    chk("s2_full_valid", 32'(instr_valid), 32'h1);
    chk("s2_full_head_pc", 32'(instr_pc), 32'h0);
    tick(); instr_ready = 1'b1; base = accepted;
    neg();
    chk("s2_c6_rom_rd", 32'(rom_rd), 32'h0);
    tick(); neg();
    chk("s2_resume_rom_rd", 32'(rom_rd), 32'h1);
    chk("s2_resume_rom_addr", 32'(rom_addr), 32'h4);
    for (int k = 8; k < 16; k++) tick();
    tick(); instr_ready = 1'b0;
    chk("s2_accepted", 32'(accepted - base), 32'd10);

    // S3: redirect with 3 buffered words and a read in flight
    tick(); redirect = 1'b1; redirect_addr = 16'h0040; exp_q.delete(); load_exp(16'h0040, 16);
    neg();
    chk("s3_redir_rom_addr", 32'(rom_addr), 32'h40);
    chk("s3_redir_rom_rd", 32'(rom_rd), 32'h1);
    tick(); redirect = 1'b0; instr_ready = 1'b1;
    neg();
    chk("s3_r1_valid", 32'(instr_valid), 32'h0);
    tick(); neg();
    chk("s3_r2_valid", 32'(instr_valid), 32'h1);
    chk("s3_r2_pc", 32'(instr_pc), 32'h40);
    chk("s3_r2_data", 32'(instr_data), 32'hA040);
    tick(); tick();

    // S4: back-to-back redirects
    tick(); redirect = 1'b1; redirect_addr = 16'h0010; exp_q.delete();
    neg();
    chk("s4_first_rom_addr", 32'(rom_addr), 32'h10);
    tick(); redirect_addr = 16'h0020; exp_q.delete(); load_exp(16'h0020, 16);
    neg();
    chk("s4_second_valid", 32'(instr_valid), 32'h0);
    chk("s4_second_rom_addr", 32'(rom_addr), 32'h20);
    tick(); redirect = 1'b0;
    neg();
    chk("s4_r1_valid", 32'(instr_valid), 32'h0);
    tick(); neg();
    chk("s4_r2_valid", 32'(instr_valid), 32'h1);
    chk("s4_r2_pc", 32'(instr_pc), 32'h20);
    chk("s4_r2_data", 32'(instr_data), 32'hA020);
    tick(); tick(); tick();

    // S5: redirect near the top of the address space
    tick(); redirect = 1'b1; redirect_addr = 16'hFFFE; exp_q.delete(); load_exp(16'hFFFE, 16);
    tick(); redirect = 1'b0;
    neg();
    chk("s5_r1_valid", 32'(instr_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); neg();
      chk("s5_wrap_pc", 32'(instr_pc), 32'(wrap_pcs[k]));
    end

    // S6: fill with ready toggling, then a one-cycle reset pulse
    for (int k = 0; k < 6; k++) begin
      tick(); instr_ready = (k % 2) == 0;
    end
    tick(); instr_ready = 1'b0;
    repeat (8) tick();
    neg();
    chk("s6_full_valid", 32'(instr_valid), 32'h1);
    chk("s6_full_rom_rd", 32'(rom_rd), 32'h0);
    tick(); reset_n = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h0077; exp_q.delete();
    neg();
    chk("s6_rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("s6_rst_rom_rd", 32'(rom_rd), 32'h0);
    chk("s6_rst_valid", 32'(instr_valid), 32'h0);
    chk("s6_rst_data", 32'(instr_data), 32'h0);
    chk("s6_rst_pc", 32'(instr_pc), 32'h0);
    tick(); reset_n = 1'b1; redirect = 1'b0; load_exp(16'h0000, 16);
    neg();
    chk("s6_c0_rom_addr", 32'(rom_addr), 32'h0);
    chk("s6_c0_rom_rd", 32'(rom_rd), 32'h1);
    chk("s6_c0_valid", 32'(instr_valid), 32'h0);
    tick(); neg();
    chk("s6_c1_valid", 32'(instr_valid), 32'h0);
    tick(); neg();
    chk("s6_c2_valid", 32'(instr_valid), 32'h1);
    chk("s6_c2_pc", 32'(instr_pc), 32'h0);
    chk("s6_c2_data", 32'(instr_data), 32'hA000);
    tick(); tick();
    tick(); instr_ready = 1'b0;
    tick(); tick();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Instruction fetch stage sitting directly upstream of the instruction processor. It generates sequential ROM addresses, absorbs the ROM's one-cycle read latency, and buffers fetched words in a small FIFO. It presents them to the processor with a valid/ready handshake, each word tagged with its address. A redirect input (taken jump / ip write) flushes buffered and in-flight words and restarts fetching at a new address.

## Interface
- WIDTH, 16, instruction word and address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_ADDR, 0, first fetch address after reset
- clock  in  1  single system clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- rom_addr  out  WIDTH  ROM address; ROM samples it on every rising edge
- rom_rd  out  1  high when the current rom_addr is a real fetch (trace/debug)
- rom_data  in  WIDTH  ROM output, valid the cycle after its address was sampled
- redirect  in  1  flush and restart fetch at redirect_addr
- redirect_addr  in  WIDTH  new fetch address, sampled when redirect=1
- instr_valid  out  1  head of FIFO holds a valid word
- instr_data  out  WIDTH  head word; 0 when instr_valid=0
- instr_pc  out  WIDTH  address of head word; 0 when instr_valid=0
- instr_ready  in  1  consumer accepts head; pop when instr_valid & instr_ready

## Operation
- State: fetch_pc (WIDTH), pending (1 bit, read issued last cycle), FIFO of DEPTH {data, pc} entries, count (0..DEPTH).
- Issue rule (no redirect): rom_rd = (count + pending < DEPTH); rom_addr = fetch_pc. On issue, fetch_pc <= fetch_pc + 1 and pending <= 1 with the issued address recorded; otherwise fetch_pc holds and pending <= 0.
- Redirect cycle: rom_addr = redirect_addr (combinational bypass), rom_rd = 1 regardless of count. Edge: FIFO emptied, count <= 0, fetch_pc <= redirect_addr + 1, pending <= 1 tagged redirect_addr. rom_data returning in this cycle is discarded. A pop in this cycle has no separate effect.
- Capture: when pending=1 and redirect=0, rom_data and its tag are pushed at the edge closing that cycle.
- Push and pop in the same cycle: count unchanged, order preserved.
- Address arithmetic modulo 2^WIDTH: fetch_pc 16'hFFFF increments to 16'h0000; redirect_addr 16'hFFFF gives fetch_pc 0.
- Overflow cannot occur: issue is credit-guarded by count + pending. A pop while empty cannot occur (instr_valid=0).
- No decode performed; words pass unmodified.

## Timing
- Reset (reset_n=0 at an edge): fetch_pc <= RESET_ADDR, pending <= 0, count <= 0.
- While reset_n=0, outputs are: rom_addr = RESET_ADDR, rom_rd = 0, instr_valid = 0, instr_data = 0, instr_pc = 0.
- Reset asserted mid-operation discards all FIFO and in-flight words; redirect is ignored while reset_n=0.
- Fetch latency is 2 cycles. Address issued in cycle t produces rom_data in t+1, which is pushed at the end of t+1; instr_valid=1 in t+2.
- Cycle 0 after reset release issues RESET_ADDR; the first instr_valid is in cycle 2.
- Redirect in cycle r gives instr_valid=1 with instr_pc=redirect_addr in cycle r+2. In cycle r+1, instr_valid=0 (flushed).
- Throughput: with instr_ready held high, one word per cycle sustained from cycle 2 onward.
- Backpressure: with instr_ready=0, the FIFO fills to exactly DEPTH words. rom_rd then drops to 0 and rom_addr holds the next unfetched address. Fetching resumes the cycle after the first pop frees a credit.
- instr_valid, instr_data and instr_pc change only on rising edges (registered FIFO head).

## Test plan
- Reset release, ROM[i]=16'hA000+i, instr_ready=1 -> cycle 2: instr_valid=1, pc=0, data=A000; then pc 1,2,3… on consecutive cycles, no bubbles.
- instr_ready=0 from release -> count reaches 4 (pcs 0–3). rom_rd=0 with rom_addr=4 held. Raise ready -> words 0,1,2,3,4… in order, none lost or duplicated.
- Redirect to 16'h0040 while FIFO holds 3 words and a read is pending -> cycle r+1 instr_valid=0; cycle r+2 pc=0x0040, data=ROM[0x40]; no pre-redirect word ever emitted.
- Back-to-back redirects to 0x10 then 0x20 on consecutive cycles -> first emitted pc is 0x20, two cycles after the second redirect; nothing from 0x10.
- Redirect to 16'hFFFE, ready=1 -> emitted pcs FFFE, FFFF, 0000, 0001.
- reset_n pulsed low for one cycle with full FIFO and ready toggling -> all outputs 0 that cycle; refetch from RESET_ADDR with first valid 2 cycles after release.
